// File: rtl/crc4_arb.sv
`default_nettype none
// ============================================================================
// Module      : crc4_arb
// Description : Two-requester round-robin arbiter in front of a shared
//               CRC engine. The winning requester's payload and the shared
//               generator polynomial are latched at grant time. The CRC is
//               the remainder of {data, WPOLY-1 zeros} modulo the latched
//               polynomial (MSB-first modulo-2 long division). The result
//               appears one cycle after the grant, with a one-cycle o_valid
//               strobe.
//
//               Sequence per operation: IDLE -> CALC -> DONE -> IDLE.
//               A request is sampled in cycle 0. The grant pulse is in
//               cycle 1. o_valid is in cycle 2. The earliest next grant is
//               in cycle 4.
//
// Optional    : `define CRC4_ARB_CHECK_EN adds check mode. This adds the
//               inputs i_crc_a/i_crc_b (expected CRC, latched with the
//               data) and the output o_match (computed == expected,
//               registered alongside o_crc).
//
// Ports       : i_clk              clock, rising edge
//               i_rst              synchronous active-high reset
//               i_req_a, i_req_b   level-held compute requests
//               i_data_a, i_data_b requester payloads (WCODE bits)
//               i_poly             shared generator polynomial (WPOLY bits)
//               i_crc_a, i_crc_b   expected CRCs (check mode only)
//               o_gnt_a, o_gnt_b   one-cycle grant pulses
//               o_valid            one-cycle result strobe
//               o_id               owner of the result (0 = A, 1 = B)
//               o_crc              CRC result (WPOLY-1 bits), held until
//                                  the next result
//               o_match            CRC compare result (check mode only)
//               o_busy             high whenever the FSM is not idle
//
// Revision    : 1.0  initial release
// ============================================================================
module crc4_arb #(
   parameter int WCODE = 4,
   parameter int WPOLY = 5
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_req_a,
   input  logic               i_req_b,
   input  logic [WCODE-1:0]   i_data_a,
   input  logic [WCODE-1:0]   i_data_b,
   input  logic [WPOLY-1:0]   i_poly,
`ifdef CRC4_ARB_CHECK_EN
   input  logic [WPOLY-2:0]   i_crc_a,
   input  logic [WPOLY-2:0]   i_crc_b,
   output logic               o_match,
`endif
   output logic               o_gnt_a,
   output logic               o_gnt_b,
   output logic               o_valid,
   output logic               o_id,
   output logic [WPOLY-2:0]   o_crc,
   output logic               o_busy
);

   localparam int WCRC = WPOLY - 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [WCODE-1:0]  r_data;    // latched winner payload
   logic [WPOLY-1:0]  r_poly;    // latched polynomial
   logic              r_owner;   // latched winner id
   logic              r_last;    // last served: 0 = A, 1 = B
   logic              r_gnt_a;
   logic              r_gnt_b;
   logic              r_valid;
   logic              r_id;
   logic [WCRC-1:0]   r_crc;
   logic              r_busy;
`ifdef CRC4_ARB_CHECK_EN
   logic [WCRC-1:0]   r_exp;     // latched expected CRC of the winner
   logic              r_match;
`endif

   logic              w_any_req;
   logic              w_pick_b;
   logic [WCRC-1:0]   w_crc;

   // Modulo-2 long division, MSB-first. The running remainder is shifted
   // left with the next dividend bit appended. When the top bit of that
   // window is 1, the full polynomial is XORed in. After all WCODE+WCRC
   // dividend bits have been consumed, the window's low WCRC bits are the
   // remainder.
   function automatic logic [WCRC-1:0] f_crc(
      input logic [WCODE-1:0] data,
      input logic [WPOLY-1:0] poly
   );
      logic [WCODE+WCRC-1:0] stream;
      logic [WPOLY-1:0]      win;
      logic [WCRC-1:0]       rem;
      stream = {data, {WCRC{1'b0}}};
      rem    = '0;
      for (int i = WCODE + WCRC - 1; i >= 0; i--) begin
         win = {rem, stream[i]};
         if (win[WPOLY-1]) begin
            win = win ^ poly;
         end
         rem = win[WCRC-1:0];
      end
      return rem;
   endfunction

   // Round-robin pick. A lone request always wins. When both requests are
   // high, the requester that was not served last wins.
   always_comb begin
      w_any_req = i_req_a | i_req_b;
      w_pick_b  = i_req_b & (~i_req_a | ~r_last);
   end

   // The datapath works purely from latched state, so the result is
   // settled during CALC.
   always_comb begin
      w_crc = f_crc(r_data, r_poly);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_data  <= '0;
         r_poly  <= '0;
         r_owner <= 1'b0;
         r_last  <= 1'b1;          // B "served last" so A wins first
         r_gnt_a <= 1'b0;
         r_gnt_b <= 1'b0;
         r_valid <= 1'b0;
         r_id    <= 1'b0;
         r_crc   <= '0;
         r_busy  <= 1'b0;
`ifdef CRC4_ARB_CHECK_EN
         r_exp   <= '0;
         r_match <= 1'b0;
`endif
      end else begin
         // Pulses default low. They are raised for exactly one cycle below.
         r_gnt_a <= 1'b0;
         r_gnt_b <= 1'b0;
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_data  <= w_pick_b ? i_data_b : i_data_a;
                  r_poly  <= i_poly;
                  r_owner <= w_pick_b;
                  r_last  <= w_pick_b;
                  r_gnt_a <= ~w_pick_b;
                  r_gnt_b <= w_pick_b;
                  r_busy  <= 1'b1;
`ifdef CRC4_ARB_CHECK_EN
                  r_exp   <= w_pick_b ? i_crc_b : i_crc_a;
`endif
                  r_state <= ST_CALC;
               end
            end
            ST_CALC: begin
               r_crc   <= w_crc;
               r_id    <= r_owner;
               r_valid <= 1'b1;
`ifdef CRC4_ARB_CHECK_EN
               r_match <= (w_crc == r_exp);
`endif
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_gnt_a = r_gnt_a;
   assign o_gnt_b = r_gnt_b;
   assign o_valid = r_valid;
   assign o_id    = r_id;
   assign o_crc   = r_crc;
   assign o_busy  = r_busy;
`ifdef CRC4_ARB_CHECK_EN
   assign o_match = r_match;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc4_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc4_arb
// Description : Directed, self-checking bench for crc4_arb. It uses
//               hand-computed CRC values for polynomial 5'b10011.
// Revision    : 1.0  initial release
// ============================================================================
module tb_crc4_arb;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_a, req_b;
   logic [3:0] data_a, data_b;
   logic [4:0] poly;
   logic       gnt_a, gnt_b, valid, id, busy;
   logic [3:0] crc;
`ifdef CRC4_ARB_CHECK_EN
   logic [3:0] crc_a, crc_b;
   logic       match;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   crc4_arb #(.WCODE(4), .WPOLY(5)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_req_a  (req_a),
      .i_req_b  (req_b),
      .i_data_a (data_a),
      .i_data_b (data_b),
      .i_poly   (poly),
`ifdef CRC4_ARB_CHECK_EN
      .i_crc_a  (crc_a),
      .i_crc_b  (crc_b),
      .o_match  (match),
`endif
      .o_gnt_a  (gnt_a),
      .o_gnt_b  (gnt_b),
      .o_valid  (valid),
      .o_id     (id),
      .o_crc    (crc),
      .o_busy   (busy)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one cycle, then settle past the edge before sampling.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
      data_a = 4'h0; data_b = 4'h0; poly = 5'b10011;
`ifdef CRC4_ARB_CHECK_EN
      crc_a = 4'h0; crc_b = 4'h0;
`endif
      tick; tick;
      check("rst_gnt_a", {7'd0, gnt_a}, 8'd0);
      check("rst_gnt_b", {7'd0, gnt_b}, 8'd0);
      check("rst_valid", {7'd0, valid}, 8'd0);
      check("rst_id",    {7'd0, id},    8'd0);
      check("rst_busy",  {7'd0, busy},  8'd0);
      check("rst_crc",   {4'd0, crc},   8'd0);
      rst = 1'b0;

      // Single A request: 1011 / 10011 -> remainder 1110.
      req_a = 1'b1; data_a = 4'b1011;
      tick;
      check("a1_gnt_a", {7'd0, gnt_a}, 8'd1);
      check("a1_gnt_b", {7'd0, gnt_b}, 8'd0);
      check("a1_busy",  {7'd0, busy},  8'd1);
      check("a1_valid_early", {7'd0, valid}, 8'd0);
      req_a = 1'b0;
      tick;
      check("a1_valid", {7'd0, valid}, 8'd1);
      check("a1_id",    {7'd0, id},    8'd0);
      check("a1_crc",   {4'd0, crc},   8'h0e);
      tick;
      check("a1_valid_drop", {7'd0, valid}, 8'd0);
      check("a1_busy_drop",  {7'd0, busy},  8'd0);
      check("a1_crc_hold",   {4'd0, crc},   8'h0e);

      // Simultaneous requests after reset: A first, then B.
      rst = 1'b1; tick; rst = 1'b0;
      req_a = 1'b1; req_b = 1'b1; data_a = 4'b0001; data_b = 4'b0000;
      tick;
      check("s_gnt_a1", {7'd0, gnt_a}, 8'd1);
      check("s_gnt_b1", {7'd0, gnt_b}, 8'd0);
      tick;
      check("s_valid1", {7'd0, valid}, 8'd1);
      check("s_id1",    {7'd0, id},    8'd0);
      check("s_crc1",   {4'd0, crc},   8'h03);
      tick;
      check("s_idle_busy", {7'd0, busy}, 8'd0);
      tick;
      check("s_gnt_a2", {7'd0, gnt_a}, 8'd0);
      check("s_gnt_b2", {7'd0, gnt_b}, 8'd1);
      req_a = 1'b0; req_b = 1'b0;
      tick;
      check("s_valid2", {7'd0, valid}, 8'd1);
      check("s_id2",    {7'd0, id},    8'd1);
      check("s_crc2",   {4'd0, crc},   8'h00);
      tick;

      // Both held for 12 cycles: grants A,B,A,B at cycles 1,4,7,10.
      req_a = 1'b1; req_b = 1'b1; data_a = 4'b0001; data_b = 4'b1011;
      for (int k = 1; k <= 12; k++) begin
         logic exp_g, exp_b;
         tick;
         exp_g = ((k - 1) % 3) == 0;
         exp_b = (((k - 1) / 3) % 2) == 1;
         check($sformatf("rr_gnt_a_c%0d", k), {7'd0, gnt_a}, {7'd0, exp_g & ~exp_b});
         check($sformatf("rr_gnt_b_c%0d", k), {7'd0, gnt_b}, {7'd0, exp_g & exp_b});
         check($sformatf("rr_excl_c%0d", k), {7'd0, gnt_a & gnt_b}, 8'd0);
         if (((k - 1) % 3) == 1) begin
            check($sformatf("rr_valid_c%0d", k), {7'd0, valid}, 8'd1);
            check($sformatf("rr_id_c%0d", k), {7'd0, id}, {7'd0, exp_b});
            check($sformatf("rr_crc_c%0d", k), {4'd0, crc}, exp_b ? 8'h0e : 8'h03);
         end
      end
      req_a = 1'b0; req_b = 1'b0;
      tick;
      check("rr_end_gnt", {6'd0, gnt_a, gnt_b}, 8'd0);
      check("rr_end_busy", {7'd0, busy}, 8'd0);
      check("rr_end_id",   {7'd0, id},   8'd1);

      // Reset pulsed in CALC aborts the operation and re-arms A-first.
      req_a = 1'b1; data_a = 4'b0001;
      tick;
      check("ra_gnt_a", {7'd0, gnt_a}, 8'd1);
      rst = 1'b1; req_a = 1'b0;
      tick;
      check("ra_valid", {7'd0, valid}, 8'd0);
      check("ra_gnt",   {6'd0, gnt_a, gnt_b}, 8'd0);
      check("ra_busy",  {7'd0, busy}, 8'd0);
      check("ra_id",    {7'd0, id},   8'd0);
      check("ra_crc",   {4'd0, crc},  8'd0);
      rst = 1'b0;
      req_a = 1'b1; req_b = 1'b1; data_a = 4'b0001; data_b = 4'b1011;
      tick;
      check("ra_next_gnt_a", {7'd0, gnt_a}, 8'd1);
      check("ra_next_gnt_b", {7'd0, gnt_b}, 8'd0);
      req_a = 1'b0; req_b = 1'b0;
      tick;
      check("ra_next_crc", {4'd0, crc}, 8'h03);
      tick;

      // Data and polynomial changes during CALC are ignored.
      req_a = 1'b1; data_a = 4'b1011; poly = 5'b10011;
      tick;
      check("hold_gnt_a", {7'd0, gnt_a}, 8'd1);
      req_a = 1'b0; data_a = 4'b0000; poly = 5'b11111;
      tick;
      check("hold_valid", {7'd0, valid}, 8'd1);
      check("hold_crc",   {4'd0, crc},   8'h0e);
      poly = 5'b10011;
      tick;

`ifdef CRC4_ARB_CHECK_EN
      // Check mode: B data 1011 with a matching, then a wrong, expected CRC.
      req_b = 1'b1; data_b = 4'b1011; crc_b = 4'b1110;
      tick;
      check("cm1_gnt_b", {7'd0, gnt_b}, 8'd1);
      req_b = 1'b0; crc_b = 4'b0000;
      tick;
      check("cm1_match", {7'd0, match}, 8'd1);
      tick;
      req_b = 1'b1; crc_b = 4'b1101;
      tick;
      req_b = 1'b0;
      tick;
      check("cm2_valid", {7'd0, valid}, 8'd1);
      check("cm2_match", {7'd0, match}, 8'd0);
      tick;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/crc4_arb.md
CRC4_ARB -- requirements
Module: crc4_arb

Interface
REQ-001 SHALL declare parameter WCODE, default 4, giving the data width in bits.
REQ-002 SHALL declare parameter WPOLY, default 5, giving the generator polynomial width in bits; the CRC width is WPOLY-1.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports i_req_a and i_req_b, input, 1 bit each: compute requests from requesters A and B.
REQ-006 SHALL have ports i_data_a and i_data_b, input, WCODE bits each: the requester payloads.
REQ-007 SHALL have port i_poly, input, WPOLY bits: the shared generator polynomial.
REQ-008 SHALL have ports o_gnt_a and o_gnt_b, output, 1 bit each: one-cycle grant pulses.
REQ-009 SHALL have port o_valid, output, 1 bit: result strobe, high for one cycle.
REQ-010 SHALL have port o_id, output, 1 bit: requester that owns the result (0 = A, 1 = B).
REQ-011 SHALL have port o_crc, output, WPOLY-1 bits: the CRC result.
REQ-012 SHALL have port o_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-014 In IDLE, when either request is high at a clock edge, the block SHALL:
- latch the winner's data, i_poly and the winner id;
- drive the winner's o_gnt high for the next cycle;
- move to CALC.
REQ-015 In IDLE with both requests low, the FSM SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin.
- When both requests are high, grant the requester not served last.
- The last-served pointer updates only on a grant.
REQ-017 From CALC, the FSM SHALL go to DONE on the next edge and register o_crc and o_id.
- o_valid SHALL be high for exactly the DONE cycle.
REQ-018 From DONE, the FSM SHALL return to IDLE unconditionally.
REQ-019 Timing SHALL be: request sampled in cycle 0, grant in cycle 1, o_valid in cycle 2, earliest next grant in cycle 4.
REQ-020 o_crc SHALL be the remainder of {data, WPOLY-1 zeros} divided by the latched polynomial, using modulo-2 long division MSB-first.
- At each step, the division SHALL XOR when the current remainder MSB is 1.
REQ-021 The datapath SHALL be combinational, from the latched registers, and valid within the CALC cycle.
REQ-022 o_crc and o_id SHALL hold their last values until the next DONE.
REQ-023 Requests SHALL be level-held until granted; a request dropped before its grant SHALL be treated as withdrawn, with no result.
REQ-024 Request and data changes during CALC or DONE SHALL be ignored; the latched values are used.
REQ-025 At most one of o_gnt_a and o_gnt_b SHALL ever be high.
REQ-026 A request held high after its grant SHALL be treated as a new request at the next IDLE, subject to round-robin.

Reset
REQ-027 While i_rst is high at a clock edge:
- FSM goes to IDLE;
- o_gnt_a, o_gnt_b, o_valid, o_id, o_busy go to 0;
- o_crc goes to 0;
- the pointer is set so that A wins first.
REQ-028 A reset asserted during CALC or DONE SHALL abort the operation with no o_valid pulse.

Configuration
REQ-029 Macro CRC4_ARB_CHECK_EN SHALL enable check mode.
- Defined: adds inputs i_crc_a and i_crc_b (WPOLY-1 bits each, latched with the data at grant) and output o_match (1 bit).
- o_match = (computed CRC == latched expected CRC), registered with o_crc; reset value 0.
REQ-030 Without CRC4_ARB_CHECK_EN, the i_crc_a, i_crc_b and o_match ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Single A request: i_req_a=1, i_data_a=4'b1011, i_poly=5'b10011 -> o_gnt_a in cycle 1; o_valid=1, o_id=0, o_crc=4'b1110 in cycle 2.
REQ-032 Simultaneous requests after reset: A data 4'b0001, B data 4'b0000, poly 5'b10011 ->
- A granted first, giving o_crc=4'b0011, o_id=0;
- then B granted, giving o_crc=4'b0000, o_id=1.
REQ-033 Both requests held continuously for 12 cycles -> grants alternate A, B, A, B; grant spacing is 3 cycles; grants are never coincident.
REQ-034 i_rst pulsed in the CALC cycle -> no o_valid; all outputs are 0 the next cycle; a following simultaneous request grants A.
REQ-035 With CRC4_ARB_CHECK_EN defined, B request with data 4'b1011 and poly 5'b10011:
- i_crc_b=4'b1110 -> o_match=1;
- i_crc_b=4'b1101 -> o_match=0.
REQ-036 i_data_a changed from 4'b1011 to 4'b0000 during CALC -> o_crc is still 4'b1110.
